// File: rtl/combat_resolver_if.sv
// Unit-facing bundle of the lane combat arbiter.
// Master drives unit state; slave is the resolver.
interface combat_resolver_if #(
    parameter int POS_W = 9,
    parameter int DMG_W = 8
) ();
    logic [POS_W-1:0] player_pos;
    logic [DMG_W-1:0] player_dmg;
    logic             player_dead;
    logic [POS_W-1:0] enemy_pos;
    logic [DMG_W-1:0] enemy_dmg;
    logic             enemy_dead;
    logic             player_moveSCEN;
    logic             player_damageSCEN;
    logic [DMG_W-1:0] player_damageIn;
    logic             enemy_moveSCEN;
    logic             enemy_damageSCEN;
    logic [DMG_W-1:0] enemy_damageIn;
    logic [DMG_W-1:0] player_base_hp;
    logic [DMG_W-1:0] enemy_base_hp;
    logic             game_over;
    logic             winner;

    modport master (
        output player_pos, player_dmg, player_dead,
        output enemy_pos, enemy_dmg, enemy_dead,
        input  player_moveSCEN, player_damageSCEN,
        input  player_damageIn,
        input  enemy_moveSCEN, enemy_damageSCEN,
        input  enemy_damageIn,
        input  player_base_hp, enemy_base_hp,
        input  game_over, winner
    );

    modport slave (
        input  player_pos, player_dmg, player_dead,
        input  enemy_pos, enemy_dmg, enemy_dead,
        output player_moveSCEN, player_damageSCEN,
        output player_damageIn,
        output enemy_moveSCEN, enemy_damageSCEN,
        output enemy_damageIn,
        output player_base_hp, enemy_base_hp,
        output game_over, winner
    );
endinterface

// File: rtl/combat_resolver.sv
// Lane combat arbiter: per game tick decides move/fight/base
// strike for one player and one enemy unit; tracks base health.
module combat_resolver #(
    parameter int POS_W    = 9,
    parameter int DMG_W    = 8,
    parameter int RANGE    = 4,
    parameter int LANE_END = 400,
    parameter int BASE_HP  = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic gameClk,
    combat_resolver_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SAMPLE, RESOLVE, STROBE, OVER
    } state_t;

    localparam logic signed [POS_W:0] RANGE_S =
        RANGE[POS_W:0];
    localparam logic [POS_W-1:0] END_P =
        LANE_END[POS_W-1:0];
    localparam logic [DMG_W-1:0] HP0 =
        BASE_HP[DMG_W-1:0];

    state_t state_q, state_d;

    logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic tick_q, tick_d;

    logic [POS_W-1:0] pp_q, pp_d, ep_q, ep_d;
    logic [DMG_W-1:0] pdmg_q, pdmg_d, edmg_q, edmg_d;
    logic             pdead_q, pdead_d;
    logic             edead_q, edead_d;

    logic pmv_q, pmv_d, emv_q, emv_d;
    logic pds_q, pds_d, eds_q, eds_d;
    logic [DMG_W-1:0] pdi_q, pdi_d, edi_q, edi_d;
    logic [DMG_W-1:0] php_q, php_d, ehp_q, ehp_d;

    logic signed [POS_W:0] gap;
    logic contact, p_alive, e_alive;

    function automatic logic [DMG_W-1:0] sat_sub(
        input logic [DMG_W-1:0] a,
        input logic [DMG_W-1:0] b
    );
        return (a > b) ? a - b : '0;
    endfunction

    always_comb begin
        s1_d   = gameClk;
        s2_d   = s1_q;
        s3_d   = s2_q;
        tick_d = s2_q & ~s3_q;
    end

    // Crossed units give a negative gap and still count as contact.
    always_comb begin
        gap = $signed({1'b0, pp_q}) - $signed({1'b0, ep_q});
        contact = (gap <= RANGE_S);
        p_alive = ~pdead_q;
        e_alive = ~edead_q;
    end

    always_comb begin
        state_d = state_q;
        pp_d    = pp_q;
        ep_d    = ep_q;
        pdmg_d  = pdmg_q;
        edmg_d  = edmg_q;
        pdead_d = pdead_q;
        edead_d = edead_q;
        pmv_d   = 1'b0;
        emv_d   = 1'b0;
        pds_d   = 1'b0;
        eds_d   = 1'b0;
        pdi_d   = pdi_q;
        edi_d   = edi_q;
        php_d   = php_q;
        ehp_d   = ehp_q;
        unique case (state_q)
            IDLE: begin
                if (tick_q) state_d = SAMPLE;
            end
            SAMPLE: begin
                pp_d    = bus.player_pos;
                ep_d    = bus.enemy_pos;
                pdmg_d  = bus.player_dmg;
                edmg_d  = bus.enemy_dmg;
                pdead_d = bus.player_dead;
                edead_d = bus.enemy_dead;
                state_d = RESOLVE;
            end
            RESOLVE: begin
                pdi_d = '0;
                edi_d = '0;
                if (p_alive && e_alive && contact) begin
                    pds_d = 1'b1;
                    eds_d = 1'b1;
                    edi_d = pdmg_q;
                    pdi_d = edmg_q;
                end else begin
                    if (e_alive) begin
                        if (ep_q >= END_P)
                            php_d = sat_sub(php_q, edmg_q);
                        else
                            emv_d = 1'b1;
                    end
                    if (p_alive) begin
                        if (pp_q == '0)
                            ehp_d = sat_sub(ehp_q, pdmg_q);
                        else
                            pmv_d = 1'b1;
                    end
                end
                state_d = STROBE;
            end
            STROBE: begin
                if (php_q == '0 || ehp_q == '0)
                    state_d = OVER;
                else
                    state_d = IDLE;
            end
            OVER: begin
                state_d = OVER;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            tick_q  <= 1'b0;
            pp_q    <= '0;
            ep_q    <= '0;
            pdmg_q  <= '0;
            edmg_q  <= '0;
            pdead_q <= 1'b0;
            edead_q <= 1'b0;
            pmv_q   <= 1'b0;
            emv_q   <= 1'b0;
            pds_q   <= 1'b0;
            eds_q   <= 1'b0;
            pdi_q   <= '0;
            edi_q   <= '0;
            php_q   <= HP0;
            ehp_q   <= HP0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            tick_q  <= tick_d;
            pp_q    <= pp_d;
            ep_q    <= ep_d;
            pdmg_q  <= pdmg_d;
            edmg_q  <= edmg_d;
            pdead_q <= pdead_d;
            edead_q <= edead_d;
            pmv_q   <= pmv_d;
            emv_q   <= emv_d;
            pds_q   <= pds_d;
            eds_q   <= eds_d;
            pdi_q   <= pdi_d;
            edi_q   <= edi_d;
            php_q   <= php_d;
            ehp_q   <= ehp_d;
        end
    end

    // Simultaneous knockout goes to the enemy.
    assign bus.player_moveSCEN   = pmv_q;
    assign bus.enemy_moveSCEN    = emv_q;
    assign bus.player_damageSCEN = pds_q;
    assign bus.enemy_damageSCEN  = eds_q;
    assign bus.player_damageIn   = pdi_q;
    assign bus.enemy_damageIn    = edi_q;
    assign bus.player_base_hp    = php_q;
    assign bus.enemy_base_hp     = ehp_q;
    assign bus.game_over         = (state_q == OVER);
    assign bus.winner            = (state_q == OVER) &&
                                   (ehp_q == '0) &&
                                   (php_q != '0);
endmodule

// File: tb/tb_combat_resolver.sv
// Directed bench for combat_resolver with a scoreboard of
// expected per-tick outcomes.
module tb_combat_resolver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic gameClk = 1'b0;

    combat_resolver_if #(.POS_W(9), .DMG_W(8)) bus ();

    combat_resolver dut (
        .clk     (clk),
        .reset   (reset),
        .gameClk (gameClk),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pm; int em; int pds; int eds;
        int pdi; int edi; int php; int ehp;
        int go; int win;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag,
                       input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic units(input int pp, input int pd,
                         input bit pdead, input int ep,
                         input int ed, input bit edead);
        bus.player_pos  = pp[8:0];
        bus.player_dmg  = pd[7:0];
        bus.player_dead = pdead;
        bus.enemy_pos   = ep[8:0];
        bus.enemy_dmg   = ed[7:0];
        bus.enemy_dead  = edead;
    endtask

    task automatic do_reset();
        gameClk = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pmove", int'(bus.player_moveSCEN), 0);
        chk("rst_pdi", int'(bus.player_damageIn), 0);
        chk("rst_php", int'(bus.player_base_hp), 255);
        chk("rst_ehp", int'(bus.enemy_base_hp), 255);
        chk("rst_go", int'(bus.game_over), 0);
        chk("rst_win", int'(bus.winner), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push(input int pm, input int em,
                        input int pds, input int eds,
                        input int pdi, input int edi,
                        input int php, input int ehp,
                        input int go, input int win);
        exp_t e;
        e.pm = pm; e.em = em; e.pds = pds; e.eds = eds;
        e.pdi = pdi; e.edi = edi; e.php = php;
        e.ehp = ehp; e.go = go; e.win = win;
        sb.push_back(e);
    endtask

    // k counts negedges after the first sampling edge T.
    task automatic run_tick(input bit dbl, input int rst_at);
        int c_pm, c_em, c_pds, c_eds, first_k, any;
        exp_t e;
        c_pm = 0; c_em = 0; c_pds = 0; c_eds = 0;
        first_k = -1;
        @(negedge clk);
        gameClk = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (dbl && k == 0) gameClk = 1'b0;
            if (dbl && k == 1) gameClk = 1'b1;
            if (k == 4) gameClk = 1'b0;
            if (k == rst_at) reset = 1'b1;
            if (k == rst_at + 2) reset = 1'b0;
            any = int'(bus.player_moveSCEN) +
                  int'(bus.enemy_moveSCEN) +
                  int'(bus.player_damageSCEN) +
                  int'(bus.enemy_damageSCEN);
            if (any != 0 && first_k < 0) first_k = k;
            c_pm  += int'(bus.player_moveSCEN);
            c_em  += int'(bus.enemy_moveSCEN);
            c_pds += int'(bus.player_damageSCEN);
            c_eds += int'(bus.enemy_damageSCEN);
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("pmove", c_pm, e.pm);
        chk("emove", c_em, e.em);
        chk("pdmg_stb", c_pds, e.pds);
        chk("edmg_stb", c_eds, e.eds);
        if (e.pm + e.em + e.pds + e.eds != 0)
            chk("latency", first_k, 5);
        chk("pdi", int'(bus.player_damageIn), e.pdi);
        chk("edi", int'(bus.enemy_damageIn), e.edi);
        chk("php", int'(bus.player_base_hp), e.php);
        chk("ehp", int'(bus.enemy_base_hp), e.ehp);
        chk("go", int'(bus.game_over), e.go);
        chk("win", int'(bus.winner), e.win);
    endtask

    initial begin
        units(200, 16, 0, 10, 32, 0);
        do_reset();

        push(1, 1, 0, 0, 0, 0, 255, 255, 0, 0);
        run_tick(0, -1);

        units(14, 16, 0, 10, 32, 0);
        push(0, 0, 1, 1, 32, 16, 255, 255, 0, 0);
        run_tick(0, -1);

        units(15, 16, 0, 10, 32, 0);
        push(1, 1, 0, 0, 0, 0, 255, 255, 0, 0);
        run_tick(0, -1);

        units(5, 7, 0, 10, 9, 0);
        push(0, 0, 1, 1, 9, 7, 255, 255, 0, 0);
        run_tick(0, -1);

        units(200, 16, 1, 400, 128, 0);
        push(0, 0, 0, 0, 0, 0, 127, 255, 0, 0);
        run_tick(0, -1);
        push(0, 0, 0, 0, 0, 0, 0, 255, 1, 0);
        run_tick(0, -1);
        units(200, 16, 0, 10, 32, 0);
        push(0, 0, 0, 0, 0, 0, 0, 255, 1, 0);
        run_tick(0, -1);

        do_reset();
        units(0, 200, 0, 50, 32, 1);
        push(0, 0, 0, 0, 0, 0, 255, 55, 0, 0);
        run_tick(0, -1);
        push(0, 0, 0, 0, 0, 0, 255, 0, 1, 1);
        run_tick(0, -1);

        do_reset();
        units(200, 16, 0, 10, 32, 0);
        push(1, 1, 0, 0, 0, 0, 255, 255, 0, 0);
        run_tick(1, -1);

        units(14, 16, 0, 10, 32, 0);
        push(0, 0, 0, 0, 0, 0, 255, 255, 0, 0);
        run_tick(0, 4);
        units(0, 200, 0, 50, 32, 1);
        push(0, 0, 0, 0, 0, 0, 255, 255, 0, 0);
        run_tick(0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout obs=running exp=done");
    end
endmodule

// File: doc/combat_resolver.md
# combat_resolver

Lane combat arbiter sitting in the game top level between one player unit and one enemy unit. On every game tick it samples both units' positions, attack power and dead flags, decides whether each unit moves, fights or strikes the opposing base, and drives the units' single-cycle move/damage strobes and damage values. It also keeps both base health counters and declares the winner. Enemy units advance toward higher positions; player units advance toward position 0.

## Interface
Parameters:
- POS_W, 9, position width
- DMG_W, 8, damage/power/health width
- RANGE, 4, contact distance in position units
- LANE_END, 400, enemy position at which the player base is struck
- BASE_HP, 255, initial health of each base

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- gameClk  in  1  slow game tick, asynchronous to clk
- player_pos  in  POS_W  player unit position
- player_dmg  in  DMG_W  player unit damageOut
- player_dead  in  1  player unit dead flag
- enemy_pos  in  POS_W  enemy unit position
- enemy_dmg  in  DMG_W  enemy unit damageOut
- enemy_dead  in  1  enemy unit dead flag
- player_moveSCEN  out  1  one-clk move strobe to player
- player_damageSCEN  out  1  one-clk damage strobe to player
- player_damageIn  out  DMG_W  damage applied to player
- enemy_moveSCEN  out  1  one-clk move strobe to enemy
- enemy_damageSCEN  out  1  one-clk damage strobe to enemy
- enemy_damageIn  out  DMG_W  damage applied to enemy
- player_base_hp  out  DMG_W  player base health
- enemy_base_hp  out  DMG_W  enemy base health
- game_over  out  1  high once either base reaches 0
- winner  out  1  valid when game_over; 1 = player won

## Operation
- gameClk passes through a 2-flop synchronizer; a rising edge yields a one-clk tick.
- FSM states: IDLE, SAMPLE, RESOLVE, STROBE, OVER.
- IDLE: on tick -> SAMPLE. Ticks seen in any other state are dropped.
- SAMPLE: register all unit inputs -> RESOLVE.
- RESOLVE uses only the registered samples:
  - gap = player_pos − enemy_pos, computed signed at POS_W+1 bits. contact = (gap <= RANGE), which includes crossed units (negative gap).
  - If both units are alive and in contact: enemy_damageIn = player_dmg, player_damageIn = enemy_dmg, both damage strobes armed, no moves.
  - Otherwise, each alive unit is handled separately:
    - Alive enemy with enemy_pos >= LANE_END: player_base_hp -= enemy_dmg, saturating at 0. No enemy move.
    - Alive player with player_pos == 0: enemy_base_hp -= player_dmg, saturating at 0. No player move.
    - Any other alive unit: its move strobe is armed.
  - A dead unit gets no strobes and deals no damage; its damageIn is 0.
  - A damageIn with no armed damage strobe is 0.
  - Both bases are updated in the same RESOLVE when both conditions hold.
- STROBE: armed strobes go high for exactly one clk.
  - If either base hp is 0 -> OVER. winner = (enemy_base_hp == 0). Both reaching 0 in the same tick gives winner = 0.
  - Otherwise -> IDLE.
- OVER: all strobes stay 0; game_over = 1; held until reset.

## Timing
- Reset values: FSM IDLE, synchronizer 0, all strobes 0, both damageIn 0, both base hp = BASE_HP, game_over 0, winner 0.
- Let T be the clk in which gameClk is first sampled high by sync stage 1.
  - Tick is high at T+2.
  - SAMPLE at T+3, RESOLVE at T+4, strobes high during T+5.
- damageIn values and base hp update at the RESOLVE→STROBE edge. damageIn is held until the next RESOLVE.
- game_over asserts the clk after STROBE.
- Minimum tick spacing: 4 clk. Closer ticks are dropped.
- Reset mid-operation returns everything to reset values immediately. Pending strobes are never emitted.

## Test plan
- Reset, then tick with player_pos=200, enemy_pos=10, both alive -> exactly one clk of player_moveSCEN=1 and enemy_moveSCEN=1; damage strobes 0; damageIn=0.
- player_pos=14, enemy_pos=10, player_dmg=16, enemy_dmg=32 -> both damageSCEN pulse once; enemy_damageIn=16; player_damageIn=32; no moves. Repeat with gap=5 -> moves only.
- enemy_pos=400, enemy_dmg=128, player_dead=1 -> player_base_hp 255→127→0 over two ticks; game_over=1 with winner=0 after the second tick; later ticks produce no strobes.
- player_pos=0, player_dmg=200, enemy_dead=1; enemy_base_hp=255 -> after the first tick enemy_base_hp=55; after the second it saturates to 0; winner=1.
- Two gameClk edges 2 clk apart -> only one set of strobes. Assert reset at the RESOLVE cycle -> no strobe pulses; hp=255.
